// File: rtl/gfx_line_arb.sv
// Round-robin arbiter sharing one Bresenham line engine between two
// line-command requesters; emits a valid/ready pixel stream.

module gfx_line #(
    parameter int XB = 10,
    parameter int YB = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          enable,
    input  logic [XB-1:0] x0,
    input  logic [YB-1:0] y0,
    input  logic [XB-1:0] x1,
    input  logic [YB-1:0] y1,
    output logic [XB-1:0] x,
    output logic [YB-1:0] y,
    output logic          done
);
    localparam int EW = ((XB > YB) ? XB : YB) + 3;

    typedef enum logic [1:0] {E_IDLE, E_P1, E_P2, E_RUN} estate_t;

    estate_t              st;
    logic [XB-1:0]        xa, xe;
    logic [YB-1:0]        ya, ye;
    logic                 sx;
    logic signed [EW-1:0] dx, dy, err, e2, err_nx;
    logic                 xs, ys;

    always_comb begin
        e2     = err <<< 1;
        xs     = e2 > -dy;
        ys     = e2 < dx;
        err_nx = err;
        if (xs) err_nx = err_nx - dy;
        if (ys) err_nx = err_nx + dx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st   <= E_IDLE;
            done <= 1'b0;
            xa   <= '0;
            ya   <= '0;
            xe   <= '0;
            ye   <= '0;
            x    <= '0;
            y    <= '0;
            sx   <= 1'b0;
            dx   <= '0;
            dy   <= '0;
            err  <= '0;
        end else begin
            done <= 1'b0;
            unique case (st)
                E_IDLE: if (start) begin
                    // Walk top-to-bottom so y only ever increments.
                    if (y0 > y1) begin
                        xa <= x1; ya <= y1; xe <= x0; ye <= y0;
                    end else begin
                        xa <= x0; ya <= y0; xe <= x1; ye <= y1;
                    end
                    st <= E_P1;
                end
                E_P1: begin
                    sx <= (xe >= xa);
                    dx <= (xe >= xa) ? EW'(xe) - EW'(xa) : EW'(xa) - EW'(xe);
                    dy <= EW'(ye) - EW'(ya);
                    st <= E_P2;
                end
                E_P2: begin
                    err <= dx - dy;
                    x   <= xa;
                    y   <= ya;
                    st  <= E_RUN;
                end
                E_RUN: if (enable) begin
                    if (x == xe && y == ye) begin
                        done <= 1'b1;
                        st   <= E_IDLE;
                    end else begin
                        err <= err_nx;
                        if (xs) x <= sx ? x + XB'(1) : x - XB'(1);
                        if (ys) y <= y + YB'(1);
                    end
                end
                default: st <= E_IDLE;
            endcase
        end
    end
endmodule

module gfx_line_arb #(
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int COLOR_BITS = 12,
    parameter int FB_X_BITS  = $clog2(FB_WIDTH),
    parameter int FB_Y_BITS  = $clog2(FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [FB_X_BITS-1:0]  s0_x0,
    input  logic [FB_Y_BITS-1:0]  s0_y0,
    input  logic [FB_X_BITS-1:0]  s0_x1,
    input  logic [FB_Y_BITS-1:0]  s0_y1,
    input  logic [COLOR_BITS-1:0] s0_color,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [FB_X_BITS-1:0]  s1_x0,
    input  logic [FB_Y_BITS-1:0]  s1_y0,
    input  logic [FB_X_BITS-1:0]  s1_x1,
    input  logic [FB_Y_BITS-1:0]  s1_y1,
    input  logic [COLOR_BITS-1:0] s1_color,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [FB_X_BITS-1:0]  pix_x,
    output logic [FB_Y_BITS-1:0]  pix_y,
    output logic [COLOR_BITS-1:0] pix_color,
    output logic                  pix_src,
    output logic                  pix_last,
    output logic                  busy
);
    typedef enum logic [2:0] {
        IDLE, START, INIT0, INIT1, DRAW, DRAIN
    } state_t;

    state_t                state;
    logic                  rr_ptr;
    logic                  gsel;
    logic [FB_X_BITS-1:0]  cmd_x0, cmd_x1, end_x;
    logic [FB_Y_BITS-1:0]  cmd_y0, cmd_y1, end_y;
    logic [COLOR_BITS-1:0] cmd_color;
    logic                  cmd_src;
    logic [FB_X_BITS-1:0]  sel_x0, sel_x1;
    logic [FB_Y_BITS-1:0]  sel_y0, sel_y1;
    logic [FB_X_BITS-1:0]  eng_x;
    logic [FB_Y_BITS-1:0]  eng_y;
    logic                  eng_start, eng_enable, eng_done;
    logic                  can_grant;

    assign gsel   = (s0_valid && s1_valid) ? rr_ptr : s1_valid;
    assign sel_x0 = gsel ? s1_x0 : s0_x0;
    assign sel_y0 = gsel ? s1_y0 : s0_y0;
    assign sel_x1 = gsel ? s1_x1 : s0_x1;
    assign sel_y1 = gsel ? s1_y1 : s0_y1;

    assign can_grant = (state == IDLE) && !reset;
    assign s0_ready  = can_grant && s0_valid && !gsel;
    assign s1_ready  = can_grant && s1_valid && gsel;

    assign eng_start  = (state == START);
    assign eng_enable = (state == DRAW) && pix_ready;

    assign pix_x     = eng_x;
    assign pix_y     = eng_y;
    assign pix_color = cmd_color;
    assign pix_src   = cmd_src;
    assign pix_last  = pix_valid && (eng_x == end_x) && (eng_y == end_y);
    assign busy      = (state != IDLE);

    gfx_line #(
        .XB(FB_X_BITS),
        .YB(FB_Y_BITS)
    ) u_line (
        .clk   (clk),
        .reset (reset),
        .start (eng_start),
        .enable(eng_enable),
        .x0    (cmd_x0),
        .y0    (cmd_y0),
        .x1    (cmd_x1),
        .y1    (cmd_y1),
        .x     (eng_x),
        .y     (eng_y),
        .done  (eng_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            pix_valid <= 1'b0;
            cmd_x0    <= '0;
            cmd_y0    <= '0;
            cmd_x1    <= '0;
            cmd_y1    <= '0;
            end_x     <= '0;
            end_y     <= '0;
            cmd_color <= '0;
            cmd_src   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (s0_valid || s1_valid) begin
                    cmd_x0    <= sel_x0;
                    cmd_y0    <= sel_y0;
                    cmd_x1    <= sel_x1;
                    cmd_y1    <= sel_y1;
                    cmd_color <= gsel ? s1_color : s0_color;
                    cmd_src   <= gsel;
                    // The engine finishes on the lower endpoint.
                    end_x     <= (sel_y0 > sel_y1) ? sel_x0 : sel_x1;
                    end_y     <= (sel_y0 > sel_y1) ? sel_y0 : sel_y1;
                    rr_ptr    <= ~gsel;
                    state     <= START;
                end
                START: state <= INIT0;
                INIT0: state <= INIT1;
                INIT1: begin
                    pix_valid <= 1'b1;
                    state     <= DRAW;
                end
                DRAW: if (pix_ready && pix_last) begin
                    pix_valid <= 1'b0;
                    state     <= DRAIN;
                end
                DRAIN: if (eng_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    a_done_in_drain: assert property (
        @(posedge clk) disable iff (reset)
        (state == DRAIN) |-> eng_done
    );
endmodule

// File: tb/tb_gfx_line_arb.sv
// Randomised bench for gfx_line_arb: drivers, passive monitor and a
// geometric line model checked per scenario.

module tb_gfx_line_arb;
    localparam int XB = 10;
    localparam int YB = 9;
    localparam int CB = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s0_valid = 1'b0, s1_valid = 1'b0;
    logic          s0_ready, s1_ready;
    logic [XB-1:0] s0_x0 = '0, s0_x1 = '0, s1_x0 = '0, s1_x1 = '0;
    logic [YB-1:0] s0_y0 = '0, s0_y1 = '0, s1_y0 = '0, s1_y1 = '0;
    logic [CB-1:0] s0_color = '0, s1_color = '0;
    logic          pix_valid, pix_ready = 1'b1;
    logic [XB-1:0] pix_x;
    logic [YB-1:0] pix_y;
    logic [CB-1:0] pix_color;
    logic          pix_src, pix_last, busy;

    always #5 clk = ~clk;

    gfx_line_arb #(
        .FB_WIDTH(640), .FB_HEIGHT(480), .COLOR_BITS(CB)
    ) dut (
        .clk(clk), .reset(reset),
        .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s0_x0(s0_x0), .s0_y0(s0_y0), .s0_x1(s0_x1), .s0_y1(s0_y1),
        .s0_color(s0_color),
        .s1_valid(s1_valid), .s1_ready(s1_ready),
        .s1_x0(s1_x0), .s1_y0(s1_y0), .s1_x1(s1_x1), .s1_y1(s1_y1),
        .s1_color(s1_color),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .pix_src(pix_src), .pix_last(pix_last), .busy(busy)
    );

    typedef struct {int x0; int y0; int x1; int y1; int color;} cmd_t;
    typedef struct {int src; cmd_t c; int cyc; bit both;} grant_t;
    typedef struct {int x; int y; int color; int src; int last;} pix_t;

    cmd_t   cq0[$], cq1[$], iq0[$], iq1[$];
    grant_t gq[$];
    pix_t   pq[$];
    int     fvq[$];
    int     cyc = 0, stab_err = 0, proto_err = 0, rdy_mode = 0;
    int     checks = 0, errors = 0, rr_model = 0;
    bit     acc0 = 0, acc1 = 0, hold_v = 0, prev_v = 0;
    logic [XB+YB+CB+1:0] hold;
    grant_t mg;
    pix_t   mp;

    // Passive monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        acc0 = s0_valid && s0_ready;
        acc1 = s1_valid && s1_ready;
        if (reset) begin
            hold_v = 0;
            prev_v = 0;
        end else begin
            if (s0_ready && s1_ready) proto_err++;
            if ((s0_ready || s1_ready) && busy) proto_err++;
            if (acc0 || acc1) begin
                mg.src  = acc1 ? 1 : 0;
                mg.c.x0 = acc1 ? int'(s1_x0) : int'(s0_x0);
                mg.c.y0 = acc1 ? int'(s1_y0) : int'(s0_y0);
                mg.c.x1 = acc1 ? int'(s1_x1) : int'(s0_x1);
                mg.c.y1 = acc1 ? int'(s1_y1) : int'(s0_y1);
                mg.c.color = acc1 ? int'(s1_color) : int'(s0_color);
                mg.cyc  = cyc;
                mg.both = s0_valid && s1_valid;
                gq.push_back(mg);
            end
            if (pix_valid) begin
                if (!prev_v) fvq.push_back(cyc);
                if (hold_v && {pix_x, pix_y, pix_color, pix_src, pix_last} !== hold)
                    stab_err++;
                if (pix_ready) begin
                    mp.x = pix_x; mp.y = pix_y; mp.color = pix_color;
                    mp.src = pix_src; mp.last = pix_last;
                    pq.push_back(mp);
                end
                hold_v = !pix_ready;
                hold   = {pix_x, pix_y, pix_color, pix_src, pix_last};
            end else begin
                if (hold_v) stab_err++;
                hold_v = 0;
            end
            prev_v = pix_valid;
        end
    end

    // Requester and sink drivers, updated just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (acc0 && cq0.size() > 0) void'(cq0.pop_front());
        if (acc1 && cq1.size() > 0) void'(cq1.pop_front());
        acc0 = 0;
        acc1 = 0;
        s0_valid = cq0.size() > 0;
        if (s0_valid) begin
            s0_x0 = XB'(cq0[0].x0); s0_y0 = YB'(cq0[0].y0);
            s0_x1 = XB'(cq0[0].x1); s0_y1 = YB'(cq0[0].y1);
            s0_color = CB'(cq0[0].color);
        end
        s1_valid = cq1.size() > 0;
        if (s1_valid) begin
            s1_x0 = XB'(cq1[0].x0); s1_y0 = YB'(cq1[0].y0);
            s1_x1 = XB'(cq1[0].x1); s1_y1 = YB'(cq1[0].y1);
            s1_color = CB'(cq1[0].color);
        end
        case (rdy_mode)
            1: pix_ready = ~pix_ready;
            2: pix_ready = 1'($urandom_range(0, 1));
            default: pix_ready = 1'b1;
        endcase
    end

    function automatic cmd_t mk(int x0, int y0, int x1, int y1, int col);
        cmd_t c;
        c.x0 = x0; c.y0 = y0; c.x1 = x1; c.y1 = y1; c.color = col;
        return c;
    endfunction

    task automatic push(int r, cmd_t c);
        if (r == 0) begin cq0.push_back(c); iq0.push_back(c); end
        else begin cq1.push_back(c); iq1.push_back(c); end
    endtask

    task automatic clear_all();
        cq0.delete(); cq1.delete(); iq0.delete(); iq1.delete();
        gq.delete(); pq.delete(); fvq.delete();
        stab_err = 0; proto_err = 0; rr_model = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        clear_all();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_idle(string tag, int maxc);
        int quiet = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (cq0.size() == 0 && cq1.size() == 0 && !s0_valid &&
                !s1_valid && !busy) quiet++;
            else quiet = 0;
            if (quiet >= 3) return;
        end
        checks++; errors++;
        $display("FAIL %s timeout: busy=%0b after %0d cycles, want idle", tag, busy, maxc);
    endtask

    // Scoreboard: every granted command against the geometric line model.
    task automatic score(string tag);
        while (gq.size() > 0) begin
            grant_t g = gq.pop_front();
            cmd_t   w;
            int ax, ay, ex, ey, dx, dy, n, stx, sty, fv;
            bit     have;
            have = (g.src == 0) ? (iq0.size() > 0) : (iq1.size() > 0);
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL %s order: grant src=%0d unexpected, want none", tag, g.src);
                continue;
            end
            w = (g.src == 0) ? iq0.pop_front() : iq1.pop_front();
            if (g.c.x0 != w.x0 || g.c.y0 != w.y0 || g.c.x1 != w.x1 ||
                g.c.y1 != w.y1 || g.c.color != w.color) begin
                errors++;
                $display("FAIL %s order: src%0d got (%0d,%0d)->(%0d,%0d) want (%0d,%0d)->(%0d,%0d)",
                         tag, g.src, g.c.x0, g.c.y0, g.c.x1, g.c.y1, w.x0, w.y0, w.x1, w.y1);
            end
            if (g.both) begin
                checks++;
                if (g.src != rr_model) begin
                    errors++;
                    $display("FAIL %s rr: winner %0d want %0d", tag, g.src, rr_model);
                end
            end
            rr_model = 1 - g.src;
            checks++;
            fv = (fvq.size() > 0) ? fvq.pop_front() : -1;
            if (fv - g.cyc != 4) begin
                errors++;
                $display("FAIL %s latency: %0d cycles want 4", tag, fv - g.cyc);
            end
            if (w.y0 > w.y1) begin ax = w.x1; ay = w.y1; ex = w.x0; ey = w.y0; end
            else begin ax = w.x0; ay = w.y0; ex = w.x1; ey = w.y1; end
            dx = ex - ax; dy = ey - ay;
            stx = (dx > 0) ? 1 : (dx < 0) ? -1 : 0;
            sty = (dy > 0) ? 1 : 0;
            n = ((dx < 0 ? -dx : dx) > dy ? (dx < 0 ? -dx : dx) : dy) + 1;
            for (int i = 0; i < n; i++) begin
                pix_t p;
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL %s pixel %0d: missing, want (%0d,%0d)",
                             tag, i, ax + i * stx, ay + i * sty);
                    break;
                end
                p = pq.pop_front();
                if (p.x != ax + i * stx || p.y != ay + i * sty ||
                    p.last != (i == n - 1) || p.color != w.color || p.src != g.src) begin
                    errors++;
                    $display("FAIL %s pixel %0d: got (%0d,%0d) last=%0d col=%0h src=%0d want (%0d,%0d) last=%0d col=%0h src=%0d",
                             tag, i, p.x, p.y, p.last, p.color, p.src,
                             ax + i * stx, ay + i * sty, i == n - 1, w.color, g.src);
                end
            end
        end
        checks++;
        if (pq.size() != 0 || iq0.size() != 0 || iq1.size() != 0) begin
            errors++;
            $display("FAIL %s leftovers: pix=%0d cmd=%0d want 0",
                     tag, pq.size(), iq0.size() + iq1.size());
        end
        checks++;
        if (stab_err != 0 || proto_err != 0) begin
            errors++;
            $display("FAIL %s protocol: stab=%0d proto=%0d want 0", tag, stab_err, proto_err);
        end
        pq.delete(); fvq.delete(); stab_err = 0; proto_err = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        push(0, mk(1, 1, 2, 2, 12'h111));
        repeat (3) @(negedge clk);
        checks++;
        if ({s0_ready, s1_ready, pix_valid, pix_last, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset outputs: rdy0=%b rdy1=%b pv=%b last=%b busy=%b want 0",
                     s0_ready, s1_ready, pix_valid, pix_last, busy);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if ({pix_valid, busy} !== 2'b0) begin
            errors++;
            $display("FAIL reset idle: pv=%b busy=%b want 0", pix_valid, busy);
        end
    endtask

    task automatic test_single_point();
        push(0, mk(5, 5, 5, 5, 12'h5a5));
        wait_idle("single", 100);
        checks++;
        if (pq.size() != 1) begin
            errors++;
            $display("FAIL single count: %0d pixels want 1", pq.size());
        end
        score("single");
    endtask

    task automatic test_horizontal();
        push(1, mk(0, 0, 3, 0, 12'hc01));
        wait_idle("horiz", 100);
        checks++;
        if (pq.size() != 4) begin
            errors++;
            $display("FAIL horiz count: %0d pixels want 4", pq.size());
        end
        score("horiz");
    endtask

    task automatic test_reversed();
        push(0, mk(4, 6, 1, 3, 12'h0f0));
        wait_idle("reversed", 100);
        score("reversed");
    endtask

    task automatic test_backpressure();
        rdy_mode = 1;
        push(0, mk(0, 0, 0, 7, 12'h777));
        wait_idle("backpr", 200);
        checks++;
        if (pq.size() != 8) begin
            errors++;
            $display("FAIL backpr count: %0d pixels want 8", pq.size());
        end
        score("backpr");
        rdy_mode = 0;
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, mk(i, 2, i + 2, 2, 12'h100 + i));
            push(1, mk(9, i, 9, i + 3, 12'h200 + i));
        end
        wait_idle("contend", 600);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= gq.size() || gq[i].src != i % 2) begin
                errors++;
                $display("FAIL contend grant %0d: src=%0d want %0d",
                         i, (i < gq.size()) ? gq[i].src : -1, i % 2);
            end
        end
        score("contend");
    endtask

    task automatic test_random();
        rdy_mode = 2;
        for (int k = 0; k < 24; k++) begin
            int r = $urandom_range(0, 1);
            int x0 = $urandom_range(12, 40), y0 = $urandom_range(12, 40);
            int len = $urandom_range(0, 11);
            int sx = $urandom_range(0, 1) ? 1 : -1;
            int sy = $urandom_range(0, 1) ? 1 : -1;
            int col = $urandom_range(0, 4095);
            case ($urandom_range(0, 3))
                0: push(r, mk(x0, y0, x0 + sx * len, y0, col));
                1: push(r, mk(x0, y0, x0, y0 + sy * len, col));
                2: push(r, mk(x0, y0, x0 + sx * len, y0 + sy * len, col));
                default: push(r, mk(x0, y0, x0, y0, col));
            endcase
        end
        wait_idle("random", 5000);
        score("random");
        rdy_mode = 0;
    endtask

    task automatic test_reset_mid_draw();
        int seen = 0;
        push(0, mk(0, 0, 30, 0, 12'habc));
        for (int i = 0; i < 100 && seen < 3; i++) begin
            @(negedge clk);
            if (pix_valid && pix_ready) seen++;
        end
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0 || seen < 3) begin
            errors++;
            $display("FAIL midreset: pv=%b busy=%b seen=%0d want 0 0 3", pix_valid, busy, seen);
        end
        clear_all();
        @(posedge clk); #2;
        reset = 1'b0;
        push(1, mk(2, 9, 6, 5, 12'h3c3));
        wait_idle("midreset", 100);
        score("midreset");
    endtask

    initial begin
        test_reset();
        test_single_point();
        test_horizontal();
        test_reversed();
        test_backpressure();
        test_contention();
        test_random();
        test_reset_mid_draw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
